// File: rtl/card_shoe_if.sv
// Handshake and status bundle between the blackjack game FSM (master)
// and the card shoe (slave).
interface card_shoe_if;
    logic       draw_req;
    logic       shuffle_req;
    logic       busy;
    logic       card_valid;
    logic [3:0] card_index;
    logic [3:0] card_val;
    logic       draw_err;
    logic       shuffle_done;
    logic [8:0] cards_left;
    logic       low_shoe;

    modport master (
        output draw_req, shuffle_req,
        input  busy, card_valid, card_index, card_val,
               draw_err, shuffle_done, cards_left, low_shoe
    );

    modport slave (
        input  draw_req, shuffle_req,
        output busy, card_valid, card_index, card_val,
               draw_err, shuffle_done, cards_left, low_shoe
    );
endinterface

// File: rtl/card_shoe.sv
// Card shoe: draws cards without replacement from NUM_DECKS decks using an
// LFSR-chosen starting rank and a linear probe over the 13 per-rank counts.
// A shuffle request refills every rank over 13 cycles.
module card_shoe #(
    parameter int          NUM_DECKS  = 1,
    parameter int          LOW_THRESH = 15,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    card_shoe_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEARCH, DELIVER, SHUFFLE} state_t;

    localparam logic [5:0] RANK_FULL = 6'(4 * NUM_DECKS);
    localparam logic [8:0] SHOE_FULL = 9'(52 * NUM_DECKS);

    state_t      state, state_nxt;
    logic [15:0] lfsr;
    logic [3:0]  ptr, ptr_nxt;
    logic [3:0]  tries, tries_nxt;
    logic [5:0]  count [0:12];
    logic [8:0]  cards_left;
    logic [3:0]  start;
    logic        hit;
    logic        take;        // consume one card of rank ptr this cycle
    logic        refill;      // rewrite count[ptr] to full this cycle
    logic        err_nxt;
    logic        done_nxt;

    // Fold the LFSR low nibble into 0..12 for the probe start.
    assign start = (lfsr[3:0] >= 4'd13) ? lfsr[3:0] - 4'd13 : lfsr[3:0];
    assign hit   = (count[ptr] != 6'd0);

    assign bus.busy       = (state != IDLE);
    assign bus.card_valid = (state == DELIVER);
    assign bus.cards_left = cards_left;
    assign bus.low_shoe   = (cards_left < 9'(LOW_THRESH));

    // Next-state and per-cycle control decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
        state_nxt = state;
        ptr_nxt   = ptr;
        tries_nxt = tries;
        take      = 1'b0;
        refill    = 1'b0;
        err_nxt   = 1'b0;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.shuffle_req) begin
                    state_nxt = SHUFFLE;
                    ptr_nxt   = 4'd0;
                end else if (bus.draw_req) begin
                    if (cards_left == 9'd0) begin
                        err_nxt = 1'b1;
                    end else begin
                        state_nxt = SEARCH;
                        ptr_nxt   = start;
                        tries_nxt = 4'd0;
                    end
                end
            end
            SEARCH: begin
                if (hit) begin
                    take      = 1'b1;
                    state_nxt = DELIVER;
                end else if (tries == 4'd12) begin
                    // Unreachable with a consistent cards_left; never spin forever.
                    state_nxt = IDLE;
                end else begin
                    ptr_nxt   = (ptr == 4'd12) ? 4'd0 : ptr + 4'd1;
                    tries_nxt = tries + 4'd1;
                end
            end
            DELIVER: begin
                state_nxt = IDLE;
            end
            SHUFFLE: begin
                refill  = 1'b1;
                ptr_nxt = ptr + 4'd1;
                if (ptr == 4'd12) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, probe pointer and LFSR registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 4'd0;
            tries <= 4'd0;
            lfsr  <= SEED;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state <= state_nxt;
            ptr   <= ptr_nxt;
            tries <= tries_nxt;
            lfsr  <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Per-rank counts and the running total of cards in the shoe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the count array is reset deliberately: a reset must leave a full shoe.
            for (int i = 0; i < 13; i++) count[i] <= RANK_FULL;
            cards_left <= SHOE_FULL;
        end else begin
            if (take) begin
                count[ptr] <= count[ptr] - 6'd1;
                cards_left <= cards_left - 9'd1;
            end else if (refill) begin
                count[ptr] <= RANK_FULL;
                if (done_nxt) cards_left <= SHOE_FULL;
            end
        end
    end

    // Latched card outputs and one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.card_index   <= 4'd0;
            bus.card_val     <= 4'd0;
            bus.draw_err     <= 1'b0;
            bus.shuffle_done <= 1'b0;
        end else begin
            bus.draw_err     <= err_nxt;
            bus.shuffle_done <= done_nxt;
            if (take) begin
                bus.card_index <= ptr;
                bus.card_val   <= (ptr == 4'd0) ? 4'd11 :
                                  (ptr >= 4'd9) ? 4'd10 : ptr + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe (NUM_DECKS=1). A reference LFSR and a rank
// tally predict every drawn card, its latency and the shoe totals.
module tb_card_shoe;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    card_shoe_if bus ();

    card_shoe #(.NUM_DECKS(1), .LOW_THRESH(15), .SEED(SEED)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] m_lfsr;
    int          m_count [13];
    int          m_left;
    int          seen    [13];

    // Reference LFSR: x^16+x^14+x^13+x^11+1, Galois, shifting right.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int start_of(input logic [15:0] l);
        int v;
        v = int'(l[3:0]);
        return (v >= 13) ? v - 13 : v;
    endfunction

    function automatic int value_of(input int rank);
        case (rank)
            0:              return 11;
            9, 10, 11, 12:  return 10;
            default:        return rank + 1;
        endcase
    endfunction

    task automatic model_full();
        for (int i = 0; i < 13; i++) m_count[i] = 4;
        m_left = 52;
    endtask

    // One draw on a non-empty shoe; want_start >= 0 delays the request
    // until the reference LFSR yields that start rank.
    task automatic draw(input int want_start, input string tag, output int lat);
        int p, n, st, waited;
        @(posedge clk); #1;
        if (want_start >= 0) begin
            waited = 0;
            while (start_of(m_lfsr) != want_start && waited < 300) begin
                @(posedge clk); #1;
                waited++;
            end
            check({tag, "_start_wait"}, int'(waited < 300), 1);
        end
        st = start_of(m_lfsr);
        bus.draw_req = 1'b1;
        @(posedge clk); #1;
        bus.draw_req = 1'b0;
        p = st;
        n = 1;
        while (m_count[p] == 0 && n < 13) begin
            p = (p == 12) ? 0 : p + 1;
            n++;
        end
        m_count[p]--;
        m_left--;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.card_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, n + 1);
        check({tag, "_index"}, int'(bus.card_index), p);
        check({tag, "_val"}, int'(bus.card_val), value_of(p));
        check({tag, "_left"}, int'(bus.cards_left), m_left);
        check({tag, "_low"}, int'(bus.low_shoe), int'(m_left < 15));
        if (lat != 0 && bus.card_index < 4'd13) seen[bus.card_index]++;
    endtask

    initial begin
        int lat;
        int flagged;
        bus.draw_req    = 1'b0;
        bus.shuffle_req = 1'b0;
        model_full();
        for (int i = 0; i < 13; i++) seen[i] = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_valid", int'(bus.card_valid), 0);
        check("rst_index", int'(bus.card_index), 0);
        check("rst_val", int'(bus.card_val), 0);
        check("rst_left", int'(bus.cards_left), 52);
        check("rst_low", int'(bus.low_shoe), 0);
        check("rst_err", int'(bus.draw_err), 0);
        check("rst_done", int'(bus.shuffle_done), 0);

        // First draw, then 50 more; the 52nd waits for a start that forces
        // a full 13-rank probe around the wrap.
        draw(-1, "draw1", lat);
        for (int d = 2; d <= 51; d++) draw(-1, $sformatf("draw%0d", d), lat);
        begin
            int r;
            r = 0;
            for (int i = 0; i < 13; i++) if (m_count[i] != 0) r = i;
            draw((r == 12) ? 0 : r + 1, "last_card", lat);
            check("last_card_13_probes", lat, 14);
        end
        for (int i = 0; i < 13; i++) check($sformatf("rank%0d_tally", i), seen[i], 4);
        check("empty_left", int'(bus.cards_left), 0);
        check("empty_low", int'(bus.low_shoe), 1);

        // Draw from an empty shoe.
        @(posedge clk); #1 bus.draw_req = 1'b1;
        @(posedge clk); #1 bus.draw_req = 1'b0;
        @(negedge clk);
        check("empty_err_pulse", int'(bus.draw_err), 1);
        check("empty_no_valid", int'(bus.card_valid), 0);
        check("empty_busy", int'(bus.busy), 0);
        @(negedge clk);
        check("empty_err_clear", int'(bus.draw_err), 0);
        flagged = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.card_valid) flagged++;
        end
        check("empty_no_card", flagged, 0);
        check("empty_left_hold", int'(bus.cards_left), 0);

        // Simultaneous shuffle and draw: shuffle wins, draw is dropped.
        @(posedge clk); #1;
        bus.shuffle_req = 1'b1;
        bus.draw_req    = 1'b1;
        @(posedge clk); #1;
        bus.shuffle_req = 1'b0;
        bus.draw_req    = 1'b0;
        flagged = 0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (bus.card_valid || bus.draw_err || bus.shuffle_done || !bus.busy) flagged++;
        end
        check("shuffle_quiet_13", flagged, 0);
        @(negedge clk);
        check("shuffle_done", int'(bus.shuffle_done), 1);
        check("shuffle_left", int'(bus.cards_left), 52);
        check("shuffle_idle", int'(bus.busy), 0);
        check("shuffle_no_err", int'(bus.draw_err), 0);
        @(negedge clk);
        check("shuffle_done_clear", int'(bus.shuffle_done), 0);
        model_full();

        // Reset during SEARCH: abort with no pulse, full shoe, LFSR back to seed.
        draw(-1, "post_shuffle", lat);
        @(posedge clk); #1 bus.draw_req = 1'b1;
        @(posedge clk); #1 bus.draw_req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_valid", int'(bus.card_valid), 0);
        check("abort_left", int'(bus.cards_left), 52);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_full();
        flagged = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus.card_valid) flagged++;
        end
        check("abort_no_card", flagged, 0);
        draw(-1, "seed_replay", lat);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
